ccip_line_reduce: RTL

CCIP_LINE_REDUCE -- requirements
Module: ccip_line_reduce

---
 rtl/ccip_line_reduce_if.sv | 24 ++
 rtl/ccip_line_reduce.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ccip_line_reduce_if.sv
// CCI-P style channel bundle for ccip_line_reduce: c0 carries line reads and
// their responses, c1 carries the single result-line write and its ack.
interface ccip_line_reduce_if;
   logic         c0_tx_valid;
   logic [41:0]  c0_tx_addr;
   logic         c0_almfull;
   logic         c0_rsp_valid;
   logic [511:0] c0_rsp_data;
   logic         c1_tx_valid;
   logic [41:0]  c1_tx_addr;
   logic [511:0] c1_tx_data;
   logic         c1_almfull;
   logic         c1_wr_ack;

   modport master (
      output c0_tx_valid, c0_tx_addr, c1_tx_valid, c1_tx_addr, c1_tx_data,
      input  c0_almfull, c0_rsp_valid, c0_rsp_data, c1_almfull, c1_wr_ack
   );

   modport slave (
      input  c0_tx_valid, c0_tx_addr, c1_tx_valid, c1_tx_addr, c1_tx_data,
      output c0_almfull, c0_rsp_valid, c0_rsp_data, c1_almfull, c1_wr_ack
   );
endinterface

// File: rtl/ccip_line_reduce.sv
// Reads num_lines cache lines, sums every unsigned element of every line and
// writes the sum (with an overflow flag in bit 511) as one result line.
module ccip_line_reduce #(
   parameter int ELEM_WIDTH      = 8,
   parameter int ACC_WIDTH       = 32,
   parameter int MAX_OUTSTANDING = 4,
   parameter int LEN_WIDTH       = 16,
   parameter int SATURATE        = 0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [41:0]           rd_base,
   input  logic [41:0]           wr_addr,
   input  logic [LEN_WIDTH-1:0]  num_lines,
   ccip_line_reduce_if.master    bus,
   output logic                  busy,
   output logic                  done,
   output logic [ACC_WIDTH-1:0]  result,
   output logic                  overflow
);
   localparam int NUM_ELEM   = 512 / ELEM_WIDTH;
   localparam int SUM_WIDTH  = ELEM_WIDTH + $clog2(NUM_ELEM);
   localparam int FULL_WIDTH = ((ACC_WIDTH > SUM_WIDTH) ? ACC_WIDTH : SUM_WIDTH) + 1;
   localparam int OUT_WIDTH  = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_WAIT_ACK} state_t;

   state_t                r_state, w_next_state;
   logic [41:0]           r_rd_base, r_wr_addr;
   logic [LEN_WIDTH-1:0]  r_num_lines, r_issued, r_received;
   logic [OUT_WIDTH-1:0]  r_outstanding;
   logic                  r_s1_valid;
   logic [SUM_WIDTH-1:0]  r_s1_sum;
   logic [ACC_WIDTH-1:0]  r_acc, r_result;
   logic                  r_overflow, r_done;
   logic                  r_c0_valid, r_c1_valid;
   logic [41:0]           r_c0_addr, r_c1_addr;
   logic [511:0]          r_c1_data;

   logic                  w_start_ok, w_issue, w_write, w_finish, w_rsp_accept;
   logic [SUM_WIDTH-1:0]  w_line_sum;
   logic [FULL_WIDTH-1:0] w_full;
   logic                  w_carry;
   logic [ACC_WIDTH-1:0]  w_acc_next;
   logic [511:0]          w_wdata;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_start_ok   = 1'b0;
      w_issue      = 1'b0;
      w_write      = 1'b0;
      w_finish     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_start_ok   = 1'b1;
               w_next_state = (num_lines == '0) ? ST_WRITE : ST_READ;
            end
         end
         ST_READ: begin
            w_issue = !bus.c0_almfull && (r_outstanding < OUT_WIDTH'(MAX_OUTSTANDING)) &&
                      (r_issued < r_num_lines);
            // Leave only once the last response has also passed through stage 2.
            if ((r_received == r_num_lines) && !r_s1_valid) w_next_state = ST_WRITE;
         end
         ST_WRITE: begin
            if (!bus.c1_almfull) begin
               w_write      = 1'b1;
               w_next_state = ST_WAIT_ACK;
            end
         end
         ST_WAIT_ACK: begin
            if (bus.c1_wr_ack) begin
               w_finish     = 1'b1;
               w_next_state = ST_IDLE;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_next_state;
   end

   assign w_rsp_accept = (r_state == ST_READ) && bus.c0_rsp_valid && (r_outstanding != '0);

   always_comb begin
      w_line_sum = '0;
      for (int i = 0; i < NUM_ELEM; i++)
         w_line_sum = w_line_sum + SUM_WIDTH'(bus.c0_rsp_data[i*ELEM_WIDTH +: ELEM_WIDTH]);
   end

   // Carry is any bit of the widened sum above the accumulator width.
   assign w_full     = FULL_WIDTH'(r_acc) + FULL_WIDTH'(r_s1_sum);
   assign w_carry    = |w_full[FULL_WIDTH-1:ACC_WIDTH];
   assign w_acc_next = ((SATURATE != 0) && w_carry) ? '1 : w_full[ACC_WIDTH-1:0];

   always_comb begin
      w_wdata                  = '0;
      w_wdata[ACC_WIDTH-1:0]   = r_acc;
      w_wdata[511]             = r_overflow;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rd_base     <= '0;
         r_wr_addr     <= '0;
         r_num_lines   <= '0;
         r_issued      <= '0;
         r_received    <= '0;
         r_outstanding <= '0;
         r_s1_valid    <= 1'b0;
         r_s1_sum      <= '0;
         r_acc         <= '0;
         r_overflow    <= 1'b0;
         r_result      <= '0;
         r_done        <= 1'b0;
         r_c0_valid    <= 1'b0;
         r_c0_addr     <= '0;
         r_c1_valid    <= 1'b0;
         r_c1_addr     <= '0;
         r_c1_data     <= '0;
      end else begin
         r_c0_valid <= w_issue;
         r_c1_valid <= w_write;
         r_done     <= w_finish;
         r_s1_valid <= w_rsp_accept;
         if (w_rsp_accept) r_s1_sum <= w_line_sum;

         if (w_start_ok) begin
            r_rd_base     <= rd_base;
            r_wr_addr     <= wr_addr;
            r_num_lines   <= num_lines;
            r_issued      <= '0;
            r_received    <= '0;
            r_outstanding <= '0;
            r_acc         <= '0;
            r_overflow    <= 1'b0;
         end else begin
            if (w_issue) begin
               r_c0_addr <= r_rd_base + 42'(r_issued);
               r_issued  <= r_issued + 1'b1;
            end
            case ({w_issue, w_rsp_accept})
               2'b10:   r_outstanding <= r_outstanding + 1'b1;
               2'b01:   r_outstanding <= r_outstanding - 1'b1;
               default: ;
            endcase
            if (w_rsp_accept) r_received <= r_received + 1'b1;
            if (r_s1_valid) begin
               r_acc      <= w_acc_next;
               r_overflow <= r_overflow | w_carry;
            end
         end

         if (w_write) begin
            r_c1_addr <= r_wr_addr;
            r_c1_data <= w_wdata;
         end
         if (w_finish) r_result <= r_acc;
      end
   end

   assign bus.c0_tx_valid = r_c0_valid;
   assign bus.c0_tx_addr  = r_c0_addr;
   assign bus.c1_tx_valid = r_c1_valid;
   assign bus.c1_tx_addr  = r_c1_addr;
   assign bus.c1_tx_data  = r_c1_data;
   assign busy            = (r_state != ST_IDLE);
   assign done            = r_done;
   assign result          = r_result;
   assign overflow        = r_overflow;
endmodule
